cic_interp_sequencer: RTL and testbench

CIC_INTERP_SEQUENCER -- requirements
Module: cic_interp_sequencer

---
 rtl/cic_seq_pkg.sv | 26 ++
 rtl/cic_seq_fifo.sv | 77 +++++++
 rtl/cic_interp_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_cic_interp_sequencer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_seq_pkg.sv
// Shared definitions for the CIC interpolator input sequencer: state
// encoding width, the state enum and matching legacy-style constants.
package cic_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    SEQ_IDLE     = 2'd0,
    SEQ_PRIME    = 2'd1,
    SEQ_RUN      = 2'd2,
    SEQ_UNDERRUN = 2'd3
  } seq_state_e;

  // Plain constants so the FSM and any legacy consumers can compare
  // against a logic vector without enum casts.
  localparam logic [STATE_W-1:0] ST_IDLE     = SEQ_IDLE;
  localparam logic [STATE_W-1:0] ST_PRIME    = SEQ_PRIME;
  localparam logic [STATE_W-1:0] ST_RUN      = SEQ_RUN;
  localparam logic [STATE_W-1:0] ST_UNDERRUN = SEQ_UNDERRUN;

  // True in the states where the divider runs and cic_req is honoured.
  function automatic logic is_streaming(input logic [STATE_W-1:0] st);
    return (st == ST_RUN) || (st == ST_UNDERRUN);
  endfunction

endpackage

// File: rtl/cic_seq_fifo.sv
// Small I/Q sample FIFO: one {real, imag} word of 2*IBITS per entry,
// registered pointers and occupancy count, synchronous flush.
// Head word is presented combinationally on rd_data.
module cic_seq_fifo #(
  parameter int IBITS = 20,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = AW + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  logic [2*IBITS-1:0] wr_data,
  output logic [2*IBITS-1:0] rd_data,
  output logic [CW-1:0]      count
);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*IBITS-1:0] mem_q [DEPTH];
  logic               do_push;
  logic               do_pop;

  // Guard push/pop against full/empty, then advance pointers and count;
  // flush wins over everything.
  always_comb begin
    do_push  = push && (count_q < CW'(DEPTH)) && !flush;
    do_pop   = pop && (count_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless once the count says empty.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/cic_interp_sequencer.sv
// CIC interpolator input sequencer: buffers upstream I/Q samples in a
// small FIFO, primes it, then hands one sample per cic_req to the
// interpolator while generating a cic_clock_en strobe every DIVIDE clocks.
// Optional build macro: CIC_SEQ_UNDERRUN_CNT_EN adds a saturating 16-bit
// underrun_count output counting zero-stuffed requests.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | disabled; divider 0, FIFO flushed, output sample zero
// PRIME    | filling FIFO; first pop once PRIME_LEVEL entries present
// RUN      | streaming; each cic_req pops the next sample
// UNDERRUN | FIFO ran dry; zeros sent until PRIME_LEVEL entries return
module cic_interp_sequencer
  import cic_seq_pkg::*;
#(
  parameter int DIVIDE      = 4,
  parameter int IBITS       = 20,
  parameter int DEPTH       = 4,
  parameter int PRIME_LEVEL = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IBITS-1:0]   in_real,
  input  logic [IBITS-1:0]   in_imag,
  output logic               cic_clock_en,
  input  logic               cic_req,
  output logic [IBITS-1:0]   cic_x_real,
  output logic [IBITS-1:0]   cic_x_imag,
  output logic               underrun,
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
  output logic [15:0]        underrun_count,
`endif
  output logic [STATE_W-1:0] state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DIVIDE);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DW-1:0]      div_q, div_d;
  logic               strobe_q, strobe_d;
  logic [IBITS-1:0]   x_re_q, x_re_d;
  logic [IBITS-1:0]   x_im_q, x_im_d;
  logic               underrun_q, underrun_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_flush;
  logic [2*IBITS-1:0] fifo_rd;
  logic [CW-1:0]      fifo_count;
  logic               have_prime;
  logic               have_any;

  cic_seq_fifo #(
    .IBITS (IBITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data ({in_real, in_imag}),
    .rd_data (fifo_rd),
    .count   (fifo_count)
  );

  assign in_ready   = (fifo_count < CW'(DEPTH));
  assign have_prime = (fifo_count >= CW'(PRIME_LEVEL));
  assign have_any   = (fifo_count != '0);
  assign fifo_flush = (state_q == ST_IDLE) || !enable;
  assign fifo_push  = in_valid && in_ready && enable && (state_q != ST_IDLE);

  // Sequencer FSM, divider/strobe and output sample selection.
  always_comb begin
    state_d    = state_q;
    div_d      = '0;
    strobe_d   = 1'b0;
    x_re_d     = x_re_q;
    x_im_d     = x_im_q;
    underrun_d = underrun_q;
    fifo_pop   = 1'b0;
    if (!enable) begin
      // Disable drops any pending strobe or pop on this edge.
      state_d    = ST_IDLE;
      x_re_d     = '0;
      x_im_d     = '0;
      underrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_PRIME;
          x_re_d     = '0;
          x_im_d     = '0;
          underrun_d = 1'b0;
        end
        ST_PRIME: begin
          if (have_prime) begin
            fifo_pop = 1'b1;
            x_re_d   = fifo_rd[2*IBITS-1:IBITS];
            x_im_d   = fifo_rd[IBITS-1:0];
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (cic_req) begin
            if (have_any) begin
              fifo_pop = 1'b1;
              x_re_d   = fifo_rd[2*IBITS-1:IBITS];
              x_im_d   = fifo_rd[IBITS-1:0];
            end else begin
              x_re_d     = '0;
              x_im_d     = '0;
              underrun_d = 1'b1;
              state_d    = ST_UNDERRUN;
            end
          end
        end
        ST_UNDERRUN: begin
          if (cic_req) begin
            // Refill to the prime level before leaving underrun so a
            // single late sample does not immediately starve again.
            if (have_prime) begin
              fifo_pop = 1'b1;
              x_re_d   = fifo_rd[2*IBITS-1:IBITS];
              x_im_d   = fifo_rd[IBITS-1:0];
              state_d  = ST_RUN;
            end else begin
              x_re_d = '0;
              x_im_d = '0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
      if (is_streaming(state_q)) begin
        div_d    = (div_q == DW'(DIVIDE - 1)) ? '0 : div_q + 1'b1;
        strobe_d = (div_q == DW'(DIVIDE - 1));
      end
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      strobe_q   <= 1'b0;
      x_re_q     <= '0;
      x_im_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      strobe_q   <= strobe_d;
      x_re_q     <= x_re_d;
      x_im_q     <= x_im_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef CIC_SEQ_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;
  logic        zero_stuff;

  // Count every request answered with a zero sample; saturate, clear in IDLE.
  always_comb begin
    zero_stuff = enable && cic_req &&
                 (((state_q == ST_RUN) && !have_any) ||
                  ((state_q == ST_UNDERRUN) && !have_prime));
    ucnt_d = ucnt_q;
    if (!enable || (state_q == ST_IDLE)) begin
      ucnt_d = '0;
    end else if (zero_stuff && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end
  end

  // Underrun counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ucnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_count = ucnt_q;
`endif

  assign state        = state_q;
  assign cic_clock_en = strobe_q;
  assign cic_x_real   = x_re_q;
  assign cic_x_imag   = x_im_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_cic_interp_sequencer.sv
// Self-checking bench for cic_interp_sequencer (DIVIDE=4, DEPTH=4,
// PRIME_LEVEL=2). A transaction-level model (sample queue, cycle count
// since streaming began) predicts every registered output each cycle.
module tb_cic_interp_sequencer;

  localparam int DIVIDE      = 4;
  localparam int IBITS       = 20;
  localparam int DEPTH       = 4;
  localparam int PRIME_LEVEL = 2;
  localparam int VW          = 5 + 2 * IBITS;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             in_valid = 1'b0;
  logic             cic_req = 1'b0;
  logic [IBITS-1:0] in_real = '0;
  logic [IBITS-1:0] in_imag = '0;
  logic             in_ready;
  logic             cic_clock_en;
  logic [IBITS-1:0] cic_x_real;
  logic [IBITS-1:0] cic_x_imag;
  logic             underrun;
  logic [1:0]       state;
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
  logic [15:0]      underrun_count;
`endif

  always #5 clock = ~clock;

  cic_interp_sequencer #(
    .DIVIDE      (DIVIDE),
    .IBITS       (IBITS),
    .DEPTH       (DEPTH),
    .PRIME_LEVEL (PRIME_LEVEL)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_real      (in_real),
    .in_imag      (in_imag),
    .cic_clock_en (cic_clock_en),
    .cic_req      (cic_req),
    .cic_x_real   (cic_x_real),
    .cic_x_imag   (cic_x_imag),
    .underrun     (underrun),
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
    .underrun_count (underrun_count),
`endif
    .state        (state)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: 0 idle, 1 priming, 2 streaming, 3 starved.
  logic [2*IBITS-1:0] m_q[$];
  int               m_state;
  logic [IBITS-1:0] m_xr, m_xi;
  bit               m_ur, m_stb;
  int               m_runcyc;
  int               m_ucnt;

  task automatic model_reset();
    m_q.delete();
    m_state  = 0;
    m_xr     = '0;
    m_xi     = '0;
    m_ur     = 1'b0;
    m_stb    = 1'b0;
    m_runcyc = 0;
    m_ucnt   = 0;
  endtask

  function automatic logic [VW-1:0] model_vec();
    return {2'(m_state), m_stb, m_ur, (m_q.size() < DEPTH), m_xr, m_xi};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {state, cic_clock_en, underrun, in_ready, cic_x_real, cic_x_imag};
  endfunction

  task automatic take_head();
    logic [2*IBITS-1:0] hd;
    hd   = m_q.pop_front();
    m_xr = hd[2*IBITS-1:IBITS];
    m_xi = hd[IBITS-1:0];
  endtask

  // Drive one cycle of inputs, advance the model by the block's rules,
  // then step past the clock edge.
  task automatic tick(input bit en, input bit v, input bit req,
                      input logic [IBITS-1:0] dr, input logic [IBITS-1:0] di);
    bit push;
    bit stb_n;
    int ns;
    enable   = en;
    in_valid = v;
    cic_req  = req;
    in_real  = dr;
    in_imag  = di;
    push = v && (m_q.size() < DEPTH) && (m_state != 0);
    if (!en) begin
      model_reset();
    end else begin
      stb_n = (m_state >= 2) && ((m_runcyc % DIVIDE) == DIVIDE - 1);
      ns = m_state;
      case (m_state)
        0: ns = 1;
        1: if (m_q.size() >= PRIME_LEVEL) begin take_head(); ns = 2; end
        2: if (req) begin
             if (m_q.size() >= 1) take_head();
             else begin
               m_xr = '0; m_xi = '0; m_ur = 1'b1; ns = 3;
               if (m_ucnt < 65535) m_ucnt++;
             end
           end
        default: if (req) begin
             if (m_q.size() >= PRIME_LEVEL) begin take_head(); ns = 2; end
             else begin
               m_xr = '0; m_xi = '0;
               if (m_ucnt < 65535) m_ucnt++;
             end
           end
      endcase
      m_runcyc = (m_state >= 2) ? m_runcyc + 1 : 0;
      if (push) m_q.push_back({dr, di});
      m_state = ns;
      m_stb   = stb_n;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    model_reset();
    @(posedge clock);
    #1;
    if (obs_vec() !== {2'd0, 1'b0, 1'b0, 1'b1, {(2*IBITS){1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", obs_vec(),
               {2'd0, 1'b0, 1'b0, 1'b1, {(2*IBITS){1'b0}}});
    end
    n_checks++;
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
    if (underrun_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_ucnt: got %0d want 0", underrun_count);
    end
    n_checks++;
`endif
    #2 reset = 1'b0;
  endtask

  task automatic test_prime();
    int n;
    int n_stb;
    int last_stb;
    tick(1, 0, 0, '0, '0);
    tick(1, 1, 0, 20'h00011, IBITS'($urandom));
    tick(1, 1, 0, 20'h00022, IBITS'($urandom));
    n = 0;
    while (m_state != 2 && n < 4) begin
      tick(1, 0, 0, '0, '0);
      n++;
    end
    if (state !== 2'd2 || cic_x_real !== 20'h00011) begin
      n_fail++;
      $display("FAIL prime_to_run: got state %0d x %h want state 2 x 00011",
               state, cic_x_real);
    end
    n_checks++;
    n_stb    = 0;
    last_stb = -1;
    for (int i = 1; i <= 16; i++) begin
      tick(1, 0, 0, '0, '0);
      if (obs_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL prime_cycle %0d: got %h want %h", cyc, obs_vec(), model_vec());
      end
      n_checks++;
      if (cic_clock_en === 1'b1) begin
        if (last_stb >= 0 && (i - last_stb) != DIVIDE) begin
          n_fail++;
          $display("FAIL strobe_period: got %0d want %0d", i - last_stb, DIVIDE);
        end
        n_checks++;
        last_stb = i;
        n_stb++;
      end
    end
    if (n_stb != 16 / DIVIDE) begin
      n_fail++;
      $display("FAIL strobe_count: got %0d want %0d", n_stb, 16 / DIVIDE);
    end
    n_checks++;
  endtask

  task automatic test_stream();
    logic [IBITS-1:0] seen[$];
    logic [IBITS-1:0] want[$];
    int next_val;
    int reqs;
    want.push_back(20'h00022);
    for (int k = 1; k <= 8; k++) want.push_back(IBITS'(k));
    next_val = 1;
    reqs     = 0;
    for (int i = 0; i < 60 && (next_val <= 8 || reqs < 9); i++) begin
      bit v;
      bit r;
      v = ((i % 4) == 0) && (next_val <= 8);
      r = m_stb && (reqs < 9);
      tick(1, v, r, IBITS'(next_val), IBITS'($urandom));
      if (v) next_val++;
      if (r) begin
        seen.push_back(cic_x_real);
        reqs++;
      end
      if (obs_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL stream_cycle %0d: got %h want %h", cyc, obs_vec(), model_vec());
      end
      n_checks++;
    end
    if (seen.size() != want.size()) begin
      n_fail++;
      $display("FAIL stream_len: got %0d want %0d", seen.size(), want.size());
    end else begin
      for (int k = 0; k < want.size(); k++) begin
        if (seen[k] !== want[k]) begin
          n_fail++;
          $display("FAIL stream_order[%0d]: got %h want %h", k, seen[k], want[k]);
        end
        n_checks++;
      end
    end
    n_checks++;
  endtask

  task automatic test_underrun();
    int n;
    logic [IBITS-1:0] a;
    a = IBITS'($urandom);
    n = 0;
    while (!m_stb && n < 10) begin tick(1, 0, 0, '0, '0); n++; end
    tick(1, 0, 1, '0, '0);
    if (state !== 2'd3 || underrun !== 1'b1 || cic_x_real !== '0 || cic_x_imag !== '0) begin
      n_fail++;
      $display("FAIL underrun_enter: got state %0d ur %0b x %h/%h want 3 1 0/0",
               state, underrun, cic_x_real, cic_x_imag);
    end
    n_checks++;
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
    if (underrun_count !== 16'd1) begin
      n_fail++;
      $display("FAIL underrun_ucnt: got %0d want 1", underrun_count);
    end
    n_checks++;
`endif
    tick(1, 1, 0, a, IBITS'($urandom));
    tick(1, 1, 0, IBITS'($urandom), IBITS'($urandom));
    n = 0;
    while (!m_stb && n < 10) begin tick(1, 0, 0, '0, '0); n++; end
    tick(1, 0, 1, '0, '0);
    if (state !== 2'd2 || cic_x_real !== a || underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_recover: got state %0d x %h ur %0b want 2 %h 1",
               state, cic_x_real, underrun, a);
    end
    n_checks++;
    if (obs_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL underrun_model: got %h want %h", obs_vec(), model_vec());
    end
    n_checks++;
  endtask

  task automatic test_disable();
    int n;
    n = 0;
    while (((m_runcyc % DIVIDE) != DIVIDE - 1) && n < 10) begin
      tick(1, 0, 0, '0, '0);
      n++;
    end
    tick(0, 1, 1, IBITS'($urandom), IBITS'($urandom));
    if (obs_vec() !== {2'd0, 1'b0, 1'b0, 1'b1, {(2*IBITS){1'b0}}}) begin
      n_fail++;
      $display("FAIL disable_idle: got %h want %h", obs_vec(),
               {2'd0, 1'b0, 1'b0, 1'b1, {(2*IBITS){1'b0}}});
    end
    n_checks++;
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
    if (underrun_count !== 16'd0) begin
      n_fail++;
      $display("FAIL disable_ucnt: got %0d want 0", underrun_count);
    end
    n_checks++;
`endif
  endtask

  task automatic test_full();
    logic [IBITS-1:0] vals[6];
    for (int k = 0; k < 6; k++) vals[k] = IBITS'($urandom);
    tick(1, 0, 0, '0, '0);
    tick(1, 1, 0, IBITS'($urandom), IBITS'($urandom));
    tick(1, 1, 0, IBITS'($urandom), IBITS'($urandom));
    tick(1, 0, 0, '0, '0);
    tick(1, 0, 1, '0, '0);
    for (int k = 0; k < 6; k++) begin
      tick(1, 1, 0, vals[k], IBITS'($urandom));
      if (in_ready !== (k < 3)) begin
        n_fail++;
        $display("FAIL full_ready push %0d: got %0b want %0b", k + 1, in_ready, (k < 3));
      end
      n_checks++;
    end
    tick(1, 1, 1, IBITS'($urandom), IBITS'($urandom));
    if (in_ready !== 1'b1 || cic_x_real !== vals[0]) begin
      n_fail++;
      $display("FAIL full_pop: got ready %0b x %h want 1 %h", in_ready, cic_x_real, vals[0]);
    end
    n_checks++;
    tick(1, 1, 1, IBITS'($urandom), IBITS'($urandom));
    if (in_ready !== 1'b1 || cic_x_real !== vals[1]) begin
      n_fail++;
      $display("FAIL pushpop_hold: got ready %0b x %h want 1 %h", in_ready, cic_x_real, vals[1]);
    end
    n_checks++;
    tick(1, 1, 0, IBITS'($urandom), IBITS'($urandom));
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_full: got ready %0b want 0", in_ready);
    end
    n_checks++;
    if (obs_vec() !== model_vec()) begin
      n_fail++;
      $display("FAIL full_model: got %h want %h", obs_vec(), model_vec());
    end
    n_checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 32) != 0, $urandom % 2, ($urandom % 3) == 0,
           IBITS'($urandom), IBITS'($urandom));
      if (obs_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL random_cycle %0d: got %h want %h", cyc, obs_vec(), model_vec());
      end
      n_checks++;
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
      if (underrun_count !== 16'(m_ucnt)) begin
        n_fail++;
        $display("FAIL random_ucnt %0d: got %0d want %0d", cyc, underrun_count, m_ucnt);
      end
      n_checks++;
`endif
    end
  endtask

  task automatic test_async_reset();
    int n;
    tick(0, 0, 0, '0, '0);
    tick(1, 0, 0, '0, '0);
    for (int k = 0; k < 3; k++) tick(1, 1, 0, IBITS'($urandom), IBITS'($urandom));
    n = 0;
    while (m_state != 2 && n < 4) begin tick(1, 0, 0, '0, '0); n++; end
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL areset_setup: got state %0d want 2", state);
    end
    n_checks++;
    #3 reset = 1'b1;
    #1;
    model_reset();
    if (obs_vec() !== {2'd0, 1'b0, 1'b0, 1'b1, {(2*IBITS){1'b0}}}) begin
      n_fail++;
      $display("FAIL areset_immediate: got %h want %h", obs_vec(),
               {2'd0, 1'b0, 1'b0, 1'b1, {(2*IBITS){1'b0}}});
    end
    n_checks++;
`ifdef CIC_SEQ_UNDERRUN_CNT_EN
    if (underrun_count !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_ucnt: got %0d want 0", underrun_count);
    end
    n_checks++;
`endif
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1, 0, 0, '0, '0);
      if (state !== 2'd1 || obs_vec() !== model_vec()) begin
        n_fail++;
        $display("FAIL areset_reprime %0d: got %h want %h", k, obs_vec(), model_vec());
      end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_prime();
    test_stream();
    test_underrun();
    test_disable();
    test_full();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
